// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared defines for the fetch stage (reset PC, bubble instruction, FSM encoding).
package if_stage_pkg;
   localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} if_state_e;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold (stall) and bubble (flush/boot) controls.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic        adel_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        adel_o
);
   logic [31:0] instr_d, instr_q, pc_d, pc_q;
   logic        adel_d, adel_q;
   // hold beats bubble so a stalled decode never loses its instruction
   always_comb begin
      instr_d = hold ? instr_q : bubble ? NOP_INSTR : instr_i;
      pc_d    = hold ? pc_q : pc_i;
      adel_d  = hold ? adel_q : !bubble && adel_i;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc_q    <= 32'h0;
         adel_q  <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         adel_q  <= adel_d;
      end
   end
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
   assign adel_o  = adel_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch (PC, pending redirect, boot FSM) feeding IF/ID; define IF_ADEL_CHECK_EN
// to flag misaligned fetch addresses as IF_ID_adel with a bubble instruction.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   output logic [31:0] IF_ID_instr,
   output logic [31:0] IF_ID_PCout,
   output logic        IF_ID_adel
);
   if_state_e   state_d, state_q;
   logic [31:0] pc_d, pc_q, pend_target_d, pend_target_q;
   logic        pend_valid_d, pend_valid_q, adel;
   logic        boot;
   assign boot = state_q == BOOT;
   // stalled redirects are parked until decode frees up; a fresh redirect always wins
   always_comb begin
      state_d       = RUN;
      pc_d          = boot || stall ? pc_q : redirect ? redirect_target :
                      pend_valid_q ? pend_target_q : pc_q + 32'd4;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (!boot && stall && redirect) begin
         pend_valid_d  = 1'b1;
         pend_target_d = redirect_target;
      end else if (!boot && !stall) begin
         pend_valid_d  = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end
`ifdef IF_ADEL_CHECK_EN
   assign adel = pc_q[1:0] != 2'b00;
`else
   assign adel = 1'b0;
`endif
   assign inst_sram_en    = 1'b1;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_wdata = 32'h0;
   assign inst_sram_addr  = pc_d;
   if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
      .clk     (clk),
      .rst     (rst),
      .hold    (stall),
      .bubble  (flush || boot),
      .instr_i (adel ? NOP_INSTR : inst_sram_rdata),
      .pc_i    (pc_q),
      .adel_i  (adel),
      .instr_o (IF_ID_instr),
      .pc_o    (IF_ID_PCout),
      .adel_o  (IF_ID_adel)
   );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench; a program-flow model predicts fetch addresses and IF/ID contents.
module tb_if_stage;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;
`ifdef IF_ADEL_CHECK_EN
   localparam bit ADEL_EN = 1'b1;
`else
   localparam bit ADEL_EN = 1'b0;
`endif
   typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic adel;} ifid_t;
   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
   logic [31:0] redirect_target = 32'h0, inst_sram_rdata = 32'h0;
   logic        inst_sram_en, IF_ID_adel;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr, inst_sram_wdata, IF_ID_instr, IF_ID_PCout;
   int          errors = 0, checks = 0;
   logic [31:0] aq[$];
   ifid_t       iq[$];
   logic        m_boot, m_pv;
   logic [31:0] m_pc, m_pt, m_prev;
   ifid_t       m_ifid;
   if_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
      .redirect_target(redirect_target), .inst_sram_en(inst_sram_en),
      .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
      .IF_ID_instr(IF_ID_instr), .IF_ID_PCout(IF_ID_PCout), .IF_ID_adel(IF_ID_adel)
   );
   always #5 clk = ~clk;
   // synchronous SRAM whose contents at address a are a^1
   always @(posedge clk) inst_sram_rdata <= inst_sram_addr ^ 32'h1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      #1;
      if (aq.size() > 0) begin
         chk("sram_addr", inst_sram_addr, aq.pop_front());
         chk("sram_ctl", {28'h0, inst_sram_en, inst_sram_wen[2:0]}, 32'h8);
      end
   end
   always @(posedge clk) begin
      ifid_t e;
      #1;
      if (iq.size() > 0) begin
         e = iq.pop_front();
         chk("ifid_instr", IF_ID_instr, e.instr);
         chk("ifid_pc", IF_ID_PCout, e.pc);
         chk("ifid_adel", {31'h0, IF_ID_adel}, {31'h0, e.adel});
      end
   end
   task automatic model_reset();
      m_boot = 1'b1; m_pv = 1'b0; m_pt = 32'h0; m_pc = RST_PC; m_prev = RST_PC;
      m_ifid = '{instr: 32'h0, pc: 32'h0, adel: 1'b0};
   endtask
   // drive one cycle of inputs and predict the fetch address and the IF/ID content after the edge
   task automatic step(input logic s, input logic f, input logic r, input logic [31:0] t);
      logic [31:0] nxt;
      logic        ad;
      stall = s; flush = f; redirect = r; redirect_target = t;
      nxt = (m_boot || s) ? m_pc : r ? t : m_pv ? m_pt : m_pc + 32'd4;
      aq.push_back(nxt);
      if (!s) begin
         if (f || m_boot) m_ifid = '{instr: 32'h0, pc: m_pc, adel: 1'b0};
         else begin
            ad = ADEL_EN && (m_pc[1:0] != 2'b00);
            m_ifid = '{instr: ad ? 32'h0 : (m_prev ^ 32'h1), pc: m_pc, adel: ad};
         end
      end
      iq.push_back(m_ifid);
      if (!m_boot && s && r) begin m_pv = 1'b1; m_pt = t; end
      else if (!m_boot && !s) m_pv = 1'b0;
      m_pc = nxt; m_prev = nxt; m_boot = 1'b0;
   endtask
   task automatic rand_cycles(input int n);
      logic [31:0] t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         t = $urandom;
         if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
         step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, t);
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(negedge clk); step(1'b0, 1'b0, 1'b0, 32'h0); end
   endtask
   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_instr", IF_ID_instr, 32'h0);
      chk("rst_pc", IF_ID_PCout, 32'h0);
      chk("rst_adel", {31'h0, IF_ID_adel}, 32'h0);
      chk("rst_addr", inst_sram_addr, RST_PC);
      chk("rst_wdata", inst_sram_wdata, 32'h0);
      @(negedge clk); rst = 1'b0; step(1'b0, 1'b0, 1'b0, 32'h0);
      idle(1);
      @(negedge clk);
      chk("first_instr", IF_ID_instr, RST_PC ^ 32'h1);
      chk("first_pc", IF_ID_PCout, RST_PC);
      step(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk); step(1'b0, 1'b0, 1'b1, 32'hBFC0_0100);
      idle(2);
      repeat (3) begin @(negedge clk); step(1'b1, 1'b0, 1'b0, 32'h0); end
      idle(2);
      @(negedge clk); step(1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
      repeat (2) begin @(negedge clk); step(1'b1, 1'b0, 1'b0, 32'h0); end
      idle(3);
      @(negedge clk); step(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk); step(1'b1, 1'b1, 1'b0, 32'h0);
      idle(2);
      rand_cycles(400);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_instr", IF_ID_instr, 32'h0);
      chk("arst_pc", IF_ID_PCout, 32'h0);
      chk("arst_adel", {31'h0, IF_ID_adel}, 32'h0);
      chk("arst_addr", inst_sram_addr, RST_PC);
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0; step(1'b0, 1'b0, 1'b0, 32'h0);
      idle(2);
      @(negedge clk); step(1'b0, 1'b0, 1'b1, 32'hBFC0_0102);
      idle(4);
      rand_cycles(300);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
